// File: rtl/mp_add_sub_pkg.sv
// Shared types and constants for the multi-precision add/sub sequencer.
package mp_add_sub_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_slice.sv
// One DATA_WD-bit add/sub slice: B is inverted for subtract, carry-in supplies the +1.
module add_sub_slice
  import mp_add_sub_pkg::*;
#(
  parameter int unsigned DATA_WD = 4
) (
  input  logic [DATA_WD-1:0] i_a,
  input  logic [DATA_WD-1:0] i_b,
  input  logic               i_mode,
  input  logic               i_c,
  output logic [DATA_WD-1:0] o_sum,
  output logic               o_c
);

  logic [DATA_WD-1:0] w_b;

  assign w_b = (i_mode == MODE_SUB) ? ~i_b : i_b;
  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{DATA_WD{1'b0}}, i_c};

endmodule

// File: rtl/mp_add_sub_seq.sv
// Wide unsigned add/sub computed one slice per cycle through a single narrow adder,
// with the carry/borrow rippled through a register.
module mp_add_sub_seq
  import mp_add_sub_pkg::*;
#(
  parameter int unsigned  DATA_WD    = 4,
  parameter int unsigned  NUM_SLICES = 4,
  localparam int unsigned TOT_WD     = DATA_WD * NUM_SLICES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [TOT_WD-1:0] i_a,
  input  logic [TOT_WD-1:0] i_b,
  input  logic              i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [TOT_WD:0]   o_result,
  output logic              o_ovr,
  output logic              o_busy
);

  localparam int unsigned IDX_WD = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  state_t              r_state, w_state_next;
  logic [TOT_WD-1:0]   r_a, r_b, r_res;
  logic                r_mode, r_carry, r_msb, r_ovr;
  logic [IDX_WD-1:0]   r_idx;
  logic [DATA_WD-1:0]  w_a_slice, w_b_slice, w_sum;
  logic                w_c, w_last;

  assign w_a_slice = r_a[r_idx*DATA_WD +: DATA_WD];
  assign w_b_slice = r_b[r_idx*DATA_WD +: DATA_WD];
  assign w_last    = (r_idx == IDX_WD'(NUM_SLICES - 1));

  add_sub_slice #(
    .DATA_WD (DATA_WD)
  ) u_slice (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_mode (r_mode),
    .i_c    (r_carry),
    .o_sum  (w_sum),
    .o_c    (w_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (i_valid) w_state_next = ST_CALC;
      ST_CALC: if (w_last)  w_state_next = ST_DONE;
      ST_DONE: if (i_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == ST_IDLE);
    o_valid = (r_state == ST_DONE);
    o_busy  = (r_state != ST_IDLE);
  end

  assign o_result = {r_msb, r_res};
  assign o_ovr    = r_ovr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_msb   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_mode  <= i_mode;
            // Subtract is A + ~B + 1, so the initial carry is the mode bit.
            r_carry <= i_mode;
            r_idx   <= '0;
            r_res   <= '0;
            r_msb   <= 1'b0;
            r_ovr   <= 1'b0;
          end
        end
        ST_CALC: begin
          r_res[r_idx*DATA_WD +: DATA_WD] <= w_sum;
          r_carry <= w_c;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_msb <= (r_mode == MODE_SUB) ? 1'b0 : w_c;
            r_ovr <= (r_mode == MODE_SUB) ? ~w_c : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sub_seq.sv
// Self-checking bench for mp_add_sub_seq (DATA_WD=4, NUM_SLICES=4): vector table,
// scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_mp_add_sub_seq;

  localparam int unsigned DATA_WD    = 4;
  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned TOT_WD     = DATA_WD * NUM_SLICES;
  localparam int          LAT        = NUM_SLICES;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, i_mode, i_ready;
  logic [TOT_WD-1:0] i_a, i_b;
  logic              o_ready, o_valid, o_ovr, o_busy;
  logic [TOT_WD:0]   o_result;

  typedef struct {
    string             name;
    logic [TOT_WD-1:0] a;
    logic [TOT_WD-1:0] b;
    logic              mode;
    logic [TOT_WD:0]   res;
    logic              ovr;
  } vec_t;

  typedef struct packed {
    logic [TOT_WD:0] res;
    logic            ovr;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  mp_add_sub_seq #(
    .DATA_WD    (DATA_WD),
    .NUM_SLICES (NUM_SLICES)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ovr    (o_ovr),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for o_ready, presents one request for a single edge and scoreboards it.
  task automatic accept(input logic [TOT_WD-1:0] a, input logic [TOT_WD-1:0] b,
                        input logic m, input logic [TOT_WD:0] er, input logic eo);
    int n = 0;
    while (!o_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_before_accept", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    i_mode  = m;
    step();
    i_valid = 1'b0;
    sbq.push_back('{res: er, ovr: eo});
  endtask

  // Called just after the accepting edge; checks latency, result and single-cycle valid.
  task automatic collect(input string nm);
    exp_t e;
    int   n = 0;
    while (!o_valid && n < 20) begin
      step();
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(LAT));
    if (sbq.size() == 0) begin
      check({nm, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({nm, "_result"}, 32'(o_result), 32'(e.res));
      check({nm, "_ovr"}, 32'(o_ovr), 32'(e.ovr));
    end
    if (i_ready) begin
      step();
      check({nm, "_valid_drop"}, 32'(o_valid), 32'd0);
      check({nm, "_ready_back"}, 32'(o_ready), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{"add_basic",   16'h1234, 16'h0FFF, 1'b0, 17'h02233, 1'b0};
    vecs[1] = '{"add_ripple",  16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0};
    vecs[2] = '{"sub_borrow",  16'h1000, 16'h0001, 1'b1, 17'h00FFF, 1'b0};
    vecs[3] = '{"sub_equal",   16'h5A5A, 16'h5A5A, 1'b1, 17'h00000, 1'b0};
    vecs[4] = '{"sub_neg",     16'h0001, 16'h0002, 1'b1, 17'h0FFFF, 1'b1};
    vecs[5] = '{"add_max",     16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0};
    vecs[6] = '{"sub_zero_mx", 16'h0000, 16'hFFFF, 1'b1, 17'h00001, 1'b1};

    rst     = 1'b1;
    i_valid = 1'b0;
    i_mode  = 1'b0;
    i_ready = 1'b1;
    i_a     = '0;
    i_b     = '0;
    #2;
    check("rst_ready",  32'(o_ready),  32'd1);
    check("rst_valid",  32'(o_valid),  32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    check("rst_ovr",    32'(o_ovr),    32'd0);
    check("rst_busy",   32'(o_busy),   32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].res, vecs[i].ovr);
      check({vecs[i].name, "_busy"}, 32'(o_busy), 32'd1);
      collect(vecs[i].name);
    end

    // Backpressure: result held while a new request waits at the input.
    i_ready = 1'b0;
    accept(16'h00FF, 16'h0F01, 1'b0, 17'h01000, 1'b0);
    collect("bp_first");
    i_valid = 1'b1;
    i_a     = 16'h2222;
    i_b     = 16'h1111;
    i_mode  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_valid_held",  32'(o_valid),  32'd1);
      check("bp_result_held", 32'(o_result), 32'h01000);
      check("bp_ready_low",   32'(o_ready),  32'd0);
    end
    i_ready = 1'b1;
    step();
    check("bp_valid_drop", 32'(o_valid), 32'd0);
    check("bp_ready_back", 32'(o_ready), 32'd1);
    sbq.push_back('{res: 17'h01111, ovr: 1'b0});
    step();
    i_valid = 1'b0;
    check("bp_second_busy", 32'(o_busy), 32'd1);
    collect("bp_second");

    // Reset during the second CALC cycle aborts the op; no result may appear.
    i_valid = 1'b1;
    i_a     = 16'h1111;
    i_b     = 16'h2222;
    i_mode  = 1'b0;
    step();
    i_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("abort_valid",  32'(o_valid),  32'd0);
    check("abort_result", 32'(o_result), 32'd0);
    check("abort_ovr",    32'(o_ovr),    32'd0);
    check("abort_busy",   32'(o_busy),   32'd0);
    check("abort_ready",  32'(o_ready),  32'd1);
    step();
    rst = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (o_valid) seen++;
      end
      check("abort_no_valid", 32'(seen), 32'd0);
    end
    accept(16'hABCD, 16'h1234, 1'b1, 17'h09999, 1'b0);
    collect("after_abort");

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
